// File: rtl/otter_pkg.sv
// Shared OTTER pipeline definitions.
// Contents:
//   - RV32I major opcode constants
//   - writeback-select code that marks a load
//   - the canonical NOP encoding (addi x0,x0,0)
//   - ctrl_t: the decoded control word carried from ID into EX
package otter_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [1:0]  RF_SEL_LOAD = 2'd2;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [3:0] alu_fun;
    logic [1:0] alu_srcA;
    logic [2:0] alu_srcB;
    logic [1:0] rf_wr_sel;
    logic       regWrite;
    logic       memWrite;
    logic       memRead2;
    logic       csr_WE;
    logic       mret_exec;
  } ctrl_t;

  // Control word of an inserted bubble: no strobe, no side effect.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection for the ID/EX boundary (purely combinational).
// Ports:
//   i_id_valid            decode slot holds a real instruction
//   i_id_opcode/funct3    fields of the decode instruction
//   i_id_rs1/i_id_rs2     source register indices of the decode instruction
//   i_ex_valid            EX holds a real instruction
//   i_ex_rf_wr_sel        EX writeback select (load when RF_SEL_LOAD)
//   i_ex_regWrite         EX writes the register file
//   i_ex_rd               EX destination register
//   i_flush / i_hold      branch-resolution flush, downstream stall
//   o_load_use            decode instruction needs the result of a load in EX
//   o_stall_id            freeze PC and IF/ID this cycle
module hazard_detect
  import otter_pkg::*;
(
  input  logic       i_id_valid,
  input  logic [6:0] i_id_opcode,
  input  logic [2:0] i_id_funct3,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_ex_valid,
  input  logic [1:0] i_ex_rf_wr_sel,
  input  logic       i_ex_regWrite,
  input  logic [4:0] i_ex_rd,
  input  logic       i_flush,
  input  logic       i_hold,
  output logic       o_load_use,
  output logic       o_stall_id
);

  logic w_uses_rs1;
  logic w_uses_rs2;
  logic w_ex_is_load;

  always_comb begin
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (i_id_opcode)
      OP_RTYPE, OP_STORE, OP_BRANCH: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_ITYPE, OP_JALR, OP_LOAD: w_uses_rs1 = 1'b1;
      // Only the register forms of CSRRW/CSRRS/CSRRC read rs1; the
      // immediate forms put a zimm in that field.
      OP_SYS: w_uses_rs1 = (i_id_funct3 inside {3'b001, 3'b010, 3'b011});
      default: ;
    endcase
  end

  // ex_memRead2 is high by default from the decoder, so the writeback
  // select is the reliable marker of a load.
  assign w_ex_is_load = i_ex_valid & (i_ex_rf_wr_sel == RF_SEL_LOAD) &
                        i_ex_regWrite & (i_ex_rd != 5'd0);

  assign o_load_use = i_id_valid & w_ex_is_load &
                      ((w_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                       (w_uses_rs2 & (i_id_rs2 == i_ex_rd)));

  // A flush kills the decode instruction, so its hazard is moot.
  assign o_stall_id = i_hold | (o_load_use & ~i_flush);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage OTTER core.
// Captures the decoded control word, operands, immediate, PC and IR into EX,
// inserts bubbles on flush or load-use, freezes on hold, and counts
// load-use bubbles in a saturating counter.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   id_*                decode-stage instruction, control and operands
//   flush, hold         kill decode instruction / freeze the stage
//   stall_id            combinational freeze request for PC and IF/ID
//   ex_*                registered EX-stage copies
//   bubble_cnt          saturating count of load-use bubbles
module id_ex_stage
  import otter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [31:0]      id_ir,
  input  logic [3:0]       id_alu_fun,
  input  logic [1:0]       id_alu_srcA,
  input  logic [2:0]       id_alu_srcB,
  input  logic [1:0]       id_rf_wr_sel,
  input  logic             id_regWrite,
  input  logic             id_memWrite,
  input  logic             id_memRead2,
  input  logic             id_csr_WE,
  input  logic             id_mret_exec,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             flush,
  input  logic             hold,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [31:0]      ex_ir,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [3:0]       ex_alu_fun,
  output logic [1:0]       ex_alu_srcA,
  output logic [2:0]       ex_alu_srcB,
  output logic [1:0]       ex_rf_wr_sel,
  output logic             ex_regWrite,
  output logic             ex_memWrite,
  output logic             ex_memRead2,
  output logic             ex_csr_WE,
  output logic             ex_mret_exec,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [31:0]      r_ir;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [XLEN-1:0]  r_imm;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_bubble_cnt;

  ctrl_t            w_id_ctrl;
  logic             w_load_use;

  // Strobes from an invalid decode slot are dropped so nothing leaks into EX.
  always_comb begin
    w_id_ctrl           = CTRL_BUBBLE;
    w_id_ctrl.alu_fun   = id_alu_fun;
    w_id_ctrl.alu_srcA  = id_alu_srcA;
    w_id_ctrl.alu_srcB  = id_alu_srcB;
    w_id_ctrl.rf_wr_sel = id_rf_wr_sel;
    w_id_ctrl.regWrite  = id_regWrite  & id_valid;
    w_id_ctrl.memWrite  = id_memWrite  & id_valid;
    w_id_ctrl.memRead2  = id_memRead2  & id_valid;
    w_id_ctrl.csr_WE    = id_csr_WE    & id_valid;
    w_id_ctrl.mret_exec = id_mret_exec & id_valid;
  end

  hazard_detect u_hazard_detect (
    .i_id_valid     (id_valid),
    .i_id_opcode    (id_ir[6:0]),
    .i_id_funct3    (id_ir[14:12]),
    .i_id_rs1       (id_ir[19:15]),
    .i_id_rs2       (id_ir[24:20]),
    .i_ex_valid     (r_valid),
    .i_ex_rf_wr_sel (r_ctrl.rf_wr_sel),
    .i_ex_regWrite  (r_ctrl.regWrite),
    .i_ex_rd        (r_ir[11:7]),
    .i_flush        (flush),
    .i_hold         (hold),
    .o_load_use     (w_load_use),
    .o_stall_id     (stall_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_ir         <= NOP_INSTR;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_ctrl       <= CTRL_BUBBLE;
      r_bubble_cnt <= '0;
    end else if (!hold) begin
      if (flush || w_load_use) begin
        // Bubble: datapath fields are don't-care once ex_valid is low.
        r_valid <= 1'b0;
        r_ir    <= NOP_INSTR;
        r_ctrl  <= CTRL_BUBBLE;
        if (!flush && (r_bubble_cnt != {CNT_W{1'b1}}))
          r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end else begin
        r_valid    <= id_valid;
        r_pc       <= id_pc;
        r_ir       <= id_ir;
        r_rs1_data <= id_rs1_data;
        r_rs2_data <= id_rs2_data;
        r_imm      <= id_imm;
        r_ctrl     <= w_id_ctrl;
      end
    end
  end

  assign ex_valid     = r_valid;
  assign ex_pc        = r_pc;
  assign ex_ir        = r_ir;
  assign ex_rs1_data  = r_rs1_data;
  assign ex_rs2_data  = r_rs2_data;
  assign ex_imm       = r_imm;
  assign ex_alu_fun   = r_ctrl.alu_fun;
  assign ex_alu_srcA  = r_ctrl.alu_srcA;
  assign ex_alu_srcB  = r_ctrl.alu_srcB;
  assign ex_rf_wr_sel = r_ctrl.rf_wr_sel;
  assign ex_regWrite  = r_ctrl.regWrite;
  assign ex_memWrite  = r_ctrl.memWrite;
  assign ex_memRead2  = r_ctrl.memRead2;
  assign ex_csr_WE    = r_ctrl.csr_WE;
  assign ex_mret_exec = r_ctrl.mret_exec;
  assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             id_valid, id_regWrite, id_memWrite, id_memRead2, id_csr_WE, id_mret_exec;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [31:0]      id_ir;
  logic [3:0]       id_alu_fun;
  logic [1:0]       id_alu_srcA, id_rf_wr_sel;
  logic [2:0]       id_alu_srcB;
  logic             flush, hold, stall_id;
  logic             ex_valid, ex_regWrite, ex_memWrite, ex_memRead2, ex_csr_WE, ex_mret_exec;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [31:0]      ex_ir;
  logic [3:0]       ex_alu_fun;
  logic [1:0]       ex_alu_srcA, ex_rf_wr_sel;
  logic [2:0]       ex_alu_srcB;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_ir(id_ir),
    .id_alu_fun(id_alu_fun), .id_alu_srcA(id_alu_srcA), .id_alu_srcB(id_alu_srcB),
    .id_rf_wr_sel(id_rf_wr_sel), .id_regWrite(id_regWrite), .id_memWrite(id_memWrite),
    .id_memRead2(id_memRead2), .id_csr_WE(id_csr_WE), .id_mret_exec(id_mret_exec),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .flush(flush), .hold(hold), .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_ir(ex_ir), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_alu_fun(ex_alu_fun), .ex_alu_srcA(ex_alu_srcA), .ex_alu_srcB(ex_alu_srcB),
    .ex_rf_wr_sel(ex_rf_wr_sel), .ex_regWrite(ex_regWrite), .ex_memWrite(ex_memWrite),
    .ex_memRead2(ex_memRead2), .ex_csr_WE(ex_csr_WE), .ex_mret_exec(ex_mret_exec),
    .bubble_cnt(bubble_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- behavioural model of the EX slot ----------------
  bit          m_valid, m_cap;
  logic [31:0] m_pc, m_ir, m_rs1, m_rs2, m_imm;
  logic [3:0]  m_alu_fun;
  logic [1:0]  m_srcA, m_rfs;
  logic [2:0]  m_srcB;
  bit          m_rw, m_mw, m_mr, m_csr, m_mret;
  int          m_cnt;
  bit          m_last_stall;

  // Which source registers an instruction reads: {rs2, rs1}.
  function automatic logic [1:0] reads(input logic [31:0] ir);
    case (ir[6:0])
      7'h33, 7'h23, 7'h63: reads = 2'b11;
      7'h13, 7'h67, 7'h03: reads = 2'b01;
      7'h73:               reads = (ir[14:12] >= 3'd1 && ir[14:12] <= 3'd3) ? 2'b01 : 2'b00;
      default:             reads = 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1,
                                      input int rs2, input logic [2:0] f3);
    enc = {7'b0, rs2[4:0], rs1[4:0], f3, rd[4:0], op};
  endfunction

  task automatic m_reset();
    m_valid = 0; m_cap = 0; m_ir = NOP; m_rw = 0; m_mw = 0; m_mr = 0; m_csr = 0;
    m_mret = 0; m_cnt = 0; m_last_stall = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, ex_valid, 0);
    chk({tag, ".ir"}, ex_ir, NOP);
    chk({tag, ".pc"}, ex_pc, 0);
    chk({tag, ".ops"}, {ex_rs1_data, ex_rs2_data}, 0);
    chk({tag, ".imm"}, ex_imm, 0);
    chk({tag, ".ctl"}, {ex_alu_fun, ex_alu_srcA, ex_alu_srcB, ex_rf_wr_sel}, 0);
    chk({tag, ".strb"}, {ex_regWrite, ex_memWrite, ex_memRead2, ex_csr_WE, ex_mret_exec}, 0);
    chk({tag, ".cnt"}, bubble_cnt, 0);
  endtask

  task automatic check_ex(input string tag);
    chk({tag, ".valid"}, ex_valid, m_valid);
    chk({tag, ".ir"}, ex_ir, m_ir);
    chk({tag, ".strb"}, {ex_regWrite, ex_memWrite, ex_memRead2, ex_csr_WE, ex_mret_exec},
        {m_rw, m_mw, m_mr, m_csr, m_mret});
    chk({tag, ".cnt"}, bubble_cnt, m_cnt);
    if (m_cap) begin
      chk({tag, ".pc"}, ex_pc, m_pc);
      chk({tag, ".ops"}, {ex_rs1_data, ex_rs2_data, ex_imm}, {m_rs1, m_rs2, m_imm});
      chk({tag, ".ctl"}, {ex_alu_fun, ex_alu_srcA, ex_alu_srcB, ex_rf_wr_sel},
          {m_alu_fun, m_srcA, m_srcB, m_rfs});
    end
  endtask

  // Drive a fresh decode instruction just after the falling edge.
  task automatic drive(input bit v, input logic [31:0] ir, input logic [1:0] rfs,
                       input bit rw, input bit mw, input bit fl, input bit hd);
    @(negedge clk);
    id_valid = v; id_ir = ir; id_rf_wr_sel = rfs; id_regWrite = rw; id_memWrite = mw;
    flush = fl; hold = hd;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_alu_fun = 4'($urandom); id_alu_srcA = 2'($urandom); id_alu_srcB = 3'($urandom);
    id_memRead2 = 1'b1;
    id_csr_WE = (ir[6:0] == 7'h73) ? 1'($urandom) : 1'b0;
    id_mret_exec = ($urandom_range(0, 7) == 0);
  endtask

  // Check stall_id before the edge, advance the model across it, check EX after.
  task automatic step(input string tag);
    logic [1:0] rd;
    logic [4:0] ex_rd;
    bit hz;
    #1;
    rd = reads(id_ir);
    ex_rd = m_ir[11:7];
    hz = id_valid && m_valid && m_rfs == 2'd2 && m_rw && ex_rd != 0 &&
         ((rd[0] && id_ir[19:15] == ex_rd) || (rd[1] && id_ir[24:20] == ex_rd));
    m_last_stall = hold || (hz && !flush);
    chk({tag, ".stall"}, stall_id, m_last_stall);
    @(posedge clk);
    if (!hold) begin
      if (flush || hz) begin
        m_valid = 0; m_cap = 0; m_ir = NOP;
        m_rw = 0; m_mw = 0; m_mr = 0; m_csr = 0; m_mret = 0;
        if (!flush && m_cnt < 15) m_cnt++;
      end else begin
        m_cap = 1; m_valid = id_valid; m_pc = id_pc; m_ir = id_ir;
        m_rs1 = id_rs1_data; m_rs2 = id_rs2_data; m_imm = id_imm;
        m_alu_fun = id_alu_fun; m_srcA = id_alu_srcA; m_srcB = id_alu_srcB; m_rfs = id_rf_wr_sel;
        m_rw = id_regWrite & id_valid; m_mw = id_memWrite & id_valid;
        m_mr = id_memRead2 & id_valid; m_csr = id_csr_WE & id_valid;
        m_mret = id_mret_exec & id_valid;
      end
    end
    #1;
    check_ex(tag);
    $display("%0t %s stall=%0b ex_valid=%0b ex_ir=%08h cnt=%0d", $time, tag, stall_id,
             ex_valid, ex_ir, bubble_cnt);
  endtask

  logic [31:0] lw_x5, add_dep, lw_x0, add_x0, lui_x5, sw_i;
  logic [6:0]  ops[10];
  int cnt_before;

  initial begin
    ops = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73};
    lw_x5   = enc(7'h03, 5, 1, 0, 3'd2);
    add_dep = enc(7'h33, 6, 5, 2, 3'd0);
    lw_x0   = enc(7'h03, 0, 1, 0, 3'd2);
    add_x0  = enc(7'h33, 6, 0, 2, 3'd0);
    lui_x5  = 32'h12345_2b7;
    sw_i    = enc(7'h23, 0, 1, 2, 3'd2);

    id_valid = 0; id_ir = NOP; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_alu_fun = 0; id_alu_srcA = 0; id_alu_srcB = 0; id_rf_wr_sel = 0;
    id_regWrite = 0; id_memWrite = 0; id_memRead2 = 0; id_csr_WE = 0; id_mret_exec = 0;
    flush = 0; hold = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk) rst_n = 1'b1;

    // Load-use: exactly one bubble, then the dependent add enters EX.
    drive(1, lw_x5, 2, 1, 0, 0, 0); step("lu.lw");
    drive(1, add_dep, 0, 1, 0, 0, 0); step("lu.stall");
    chk("lu.bubble", ex_valid, 0);
    step("lu.add");
    chk("lu.add_ir", ex_ir, add_dep);
    chk("lu.cnt", bubble_cnt, 1);

    // No false stalls: load to x0, and a non-reading lui after a load.
    drive(1, lw_x0, 2, 1, 0, 0, 0); step("x0.lw");
    drive(1, add_x0, 0, 1, 0, 0, 0); step("x0.add");
    chk("x0.nostall", ex_ir, add_x0);
    drive(1, lw_x5, 2, 1, 0, 0, 0); step("lui.lw");
    drive(1, lui_x5, 0, 1, 0, 0, 0); step("lui.lui");
    chk("lui.nostall", ex_ir, lui_x5);

    // Flush beats load-use: bubble, no stall, counter untouched.
    drive(1, lw_x5, 2, 1, 0, 0, 0); step("fl.lw");
    cnt_before = int'(bubble_cnt);
    drive(1, add_dep, 0, 1, 0, 1, 0); step("fl.add");
    chk("fl.cnt", bubble_cnt, cnt_before);

    // Hold beats flush: the store stays frozen in EX, then flush bubbles it.
    drive(1, sw_i, 0, 0, 1, 0, 0); step("hd.sw");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); flush = 1; hold = 1;
      step("hd.hold");
      chk("hd.mw", ex_memWrite, 1);
    end
    @(negedge clk); hold = 0;
    step("hd.flush");
    chk("hd.bubble", ex_valid, 0);

    // Random traffic; a stalled decode slot is kept unchanged, as IF/ID would be.
    for (int i = 0; i < 300; i++) begin
      if (m_last_stall) begin
        @(negedge clk);
        flush = ($urandom_range(0, 9) == 0);
        hold  = ($urandom_range(0, 9) == 0);
      end else begin
        logic [6:0] op;
        logic [31:0] ir;
        op = ops[$urandom_range(0, 9)];
        ir = enc(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 3'($urandom));
        drive($urandom_range(0, 9) != 0, ir,
              (op == 7'h03) ? 2'd2 : 2'($urandom_range(0, 3)),
              $urandom_range(0, 9) != 0, op == 7'h23,
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      end
      step("rnd");
    end

    // Asynchronous reset between edges, no clock needed.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    m_reset();
    flush = 0; hold = 0;
    @(negedge clk) rst_n = 1'b1;

    // 17 back-to-back load-use pairs saturate the 4-bit counter at 15.
    for (int i = 0; i < 17; i++) begin
      drive(1, lw_x5, 2, 1, 0, 0, 0); step("sat.lw");
      drive(1, add_dep, 0, 1, 0, 0, 0); step("sat.stall");
      step("sat.add");
    end
    chk("sat.cnt", bubble_cnt, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the 5-stage OTTER pipeline. Sits directly downstream of the control decoder, register file and immediate generator.
- Registers the decoded control word, operands, PC and IR into the EX stage.
- Detects load-use hazards, inserts bubbles, and honours flush from branch/jump resolution and hold from the memory stage.
- Keeps a saturating bubble counter for performance measurement.

Parameters:
- XLEN, 32, datapath width for PC, IR, operands and immediate.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_pc  in  XLEN  PC of the decode instruction.
- id_ir  in  32  raw instruction; opcode, rd, rs1, rs2 and funct3 are extracted internally.
- id_alu_fun  in  4  decoder ALU function.
- id_alu_srcA  in  2  decoder ALU operand A select.
- id_alu_srcB  in  3  decoder ALU operand B select.
- id_rf_wr_sel  in  2  decoder writeback select; value 2 means load.
- id_regWrite, id_memWrite, id_memRead2, id_csr_WE, id_mret_exec  in  1 each  decoder strobes.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_imm  in  XLEN  selected immediate.
- flush  in  1  taken branch/jump/trap resolved in EX; kills the decode instruction.
- hold  in  1  downstream stall (memory wait); freezes ID/EX.
- stall_id  out  1  combinational; freeze PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_ir, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN/32  registered copies.
- ex_alu_fun, ex_alu_srcA, ex_alu_srcB, ex_rf_wr_sel  out  4/2/3/2  registered control.
- ex_regWrite, ex_memWrite, ex_memRead2, ex_csr_WE, ex_mret_exec  out  1 each  registered control, gated by validity.
- bubble_cnt  out  CNT_W  number of load-use bubbles inserted, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All ex_* outputs go to 0, ex_valid=0, bubble_cnt=0.
  - ex_ir resets to 32'h00000013 (NOP).
  - Reset takes effect immediately, even mid-stall or mid-flush.
- Register-usage decode from id_ir[6:0]:
  - uses_rs1 for opcodes 0110011, 0010011, 1100111, 0000011, 0100011 and 1100011, and for 1110011 when funct3 is 001..011.
  - uses_rs2 for opcodes 0110011, 0100011 and 1100011.
- Load in EX is identified by ex_valid & ex_rf_wr_sel==2. ex_memRead2 is not used for this, because the decoder drives it high by default.
- load_use = id_valid & ex_valid & ex_rf_wr_sel==2 & ex_regWrite & ex_ir[11:7]!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- stall_id = hold | (load_use & ~flush). It is purely combinational, with no extra latency.
- Per-edge update, in priority order:
  1. hold: every ex_* register and bubble_cnt keep their values, and flush is ignored. The flush source stays asserted because the EX contents are frozen.
  2. flush: insert a bubble. ex_valid=0, all strobes (regWrite, memWrite, csr_WE, mret_exec) cleared, ex_ir=NOP, memRead2 cleared. bubble_cnt does not change.
  3. load_use: insert a bubble as in step 2, and bubble_cnt increments by 1, saturating at all-ones.
  4. Otherwise: capture all id_* inputs, with ex_valid=id_valid.
- Whenever id_valid=0 is captured, all strobes are forced to 0. No side effect may leak from an invalid slot.
- Load-use latency:
  - Exactly one bubble per load-use pair.
  - The dependent instruction enters EX on the second edge after detection; it is not re-detected because EX then holds the bubble.
- Loads to x0 never stall.
- A load followed by a non-dependent instruction never stalls.
- Operands are captured as-is. Forwarding is handled downstream in EX.

Decomposition:
- The shared otter_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ITYPE, OP_JALR, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_SYS);
  - RF_SEL_LOAD=2 and NOP_INSTR;
  - the packed struct ctrl_t, bundling alu_fun, srcA, srcB, rf_wr_sel and the five strobes.
- One sub-module, hazard_detect: purely combinational load_use and stall_id generation.
- The pipeline register and bubble counter stay in id_ex_stage.

Test Plan:
- Reset mid-run: assert rst_n=0 between edges -> all ex_* outputs 0, ex_ir=32'h13 and bubble_cnt=0 immediately, with no clock needed.
- Load-use stall: lw x5,0(x1) then add x6,x5,x2 -> one cycle with stall_id=1, one EX bubble with ex_valid=0, then add in EX; bubble_cnt=1.
- No false stall:
  - lw x0,0(x1) then add x6,x0,x2 -> stall_id never asserted;
  - lw x5 then lui x5,0x12345 -> stall_id never asserted.
- Flush vs load-use: flush=1 in the same cycle as load_use -> bubble inserted, stall_id=0, bubble_cnt unchanged.
- Hold priority: hold=1 for 3 cycles with flush=1 -> ex_* frozen with the original store still ex_memWrite=1; after hold drops, flush produces a bubble.
- Counter saturation with CNT_W=4: 17 back-to-back load-use pairs -> bubble_cnt stops at 15.
